match_controller: RTL
=====================

// Module: match_controller
// PURPOSE
//   Round/match sequencer for the two-player fighter. Watches both players' health
//   (from health_status) and sequences IDLE -> countdown -> fight -> KO -> next round
//   or match over. Drives round_rst to player/health_status, gates player inputs via
//   fight_enable, and drives scores, round number and countdown onto HEX0..HEX5.
// PARAMETERS
//   HEALTH_W        3    width of player health inputs
//   FPS             60   frame_tick pulses per countdown second
//   COUNTDOWN_SECS  3    countdown length in seconds (1..3)
//   KO_FRAMES       120  frame_ticks held in KO before advancing
//   ROUNDS_TO_WIN   2    round wins that end the match (1..3)
// PORTS
//   clk             in   1         system clock (single domain)
//   rst             in   1         synchronous, active-high reset
//   frame_tick      in   1         one-cycle pulse per video frame
//   start           in   1         one-cycle pulse (debounced KEY) to start/restart
//   player1_health  in   HEALTH_W  P1 health; 0 = knocked out
//   player2_health  in   HEALTH_W  P2 health; 0 = knocked out
//   round_rst       out  1         one-cycle pulse: reset players + health for new round
//   fight_enable    out  1         1 only in FIGHT; ANDed with player controls upstream
//   match_state     out  3         encoded FSM state (enum in package)
//   p1_wins         out  2         P1 rounds won this match
//   p2_wins         out  2         P2 rounds won this match
//   round_num       out  4         current round, 1..9, saturating
//   winner          out  2         00 none, 01 P1, 10 P2; valid in MATCH_OVER
//   HEX0..HEX5      out  7 each    active-low 7-seg, registered
// BEHAVIOUR
//   Reset: state IDLE; wins 0; round_num 1; winner 00; round_rst 0; fight_enable 0;
//     all counters 0; HEX all 7'h7F (blank). rst mid-operation -> IDLE next edge,
//     no round_rst pulse.
//   IDLE: start -> ROUND_RST. Other inputs ignored.
//   ROUND_RST: round_rst=1 for exactly this one cycle; load sec=COUNTDOWN_SECS,
//     frame counter=0; -> COUNTDOWN unconditionally.
//   COUNTDOWN: on frame_tick, frame counter increments; at FPS-1 it wraps to 0 and
//     sec decrements; when sec would reach 0 -> FIGHT. Health ignored (may be stale).
//   FIGHT: fight_enable=1 (registered, high the cycle after entry). Each cycle
//     sample health: both 0 -> draw, no win change; only P1=0 -> p2_wins+1; only
//     P2=0 -> p1_wins+1. Any KO -> KO state, KO counter=0, fight_enable low next cycle.
//   KO: count frame_ticks; after KO_FRAMES ticks: if p1_wins or p2_wins ==
//     ROUNDS_TO_WIN -> MATCH_OVER (winner set same edge); else round_num+1
//     (saturate at 9) -> ROUND_RST.
//   MATCH_OVER: hold; start -> clear wins, round_num=1, winner=00 -> ROUND_RST.
//   start outside IDLE/MATCH_OVER is ignored. frame_tick and start coincident: both
//   honoured by the state they apply to. Wins never exceed ROUNDS_TO_WIN.
//   HEX map (1-cycle latency from state/counters): HEX5 p1_wins, HEX0 p2_wins,
//     HEX3 round_num, HEX2 sec in COUNTDOWN else blank, HEX1/HEX4 blank except
//     MATCH_OVER: HEX4 'P', HEX1 winner digit 1/2.
// STRUCTURE
//   Shared package: match_state_t enum (IDLE, ROUND_RST, COUNTDOWN, FIGHT, KO,
//     MATCH_OVER), winner encodings, SEG_BLANK=7'h7F, SEG_P glyph.
//   Sub-module: seg7_decoder (4-bit digit -> 7-bit active-low, combinational),
//     instanced per digit; FSM, counters and output registers in this module.
// TESTING (bench params FPS=2, COUNTDOWN_SECS=3, KO_FRAMES=4, ROUNDS_TO_WIN=2)
//   rst then idle 20 cycles, no start -> state IDLE, round_rst never high, HEX all 7F.
//   start pulse -> round_rst high exactly 1 cycle; fight_enable rises after 6
//     frame_ticks; HEX2 shows 3,2,1 during countdown.
//   In FIGHT drive P2 health 0 -> p1_wins=1, fight_enable low next cycle; 4 ticks
//     later round_rst pulse, round_num=2.
//   Both healths 0 same cycle -> wins unchanged, round_num advances after KO.
//   P1 wins two rounds -> MATCH_OVER, winner=01, HEX4 'P', HEX1 '1'; start ->
//     wins 0, round_num 1, round_rst pulse.
//   Health 0 during COUNTDOWN, and rst asserted mid-KO -> no win counted; IDLE.

Source files
------------

// File: rtl/match_controller_pkg.sv
// Shared types and constants for the two-player round/match sequencer.
// Holds the state encoding, winner codes, 7-seg glyphs and a small round helper.
package match_controller_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ROUND_RST  = 3'd1,
    COUNTDOWN  = 3'd2,
    FIGHT      = 3'd3,
    KO         = 3'd4,
    MATCH_OVER = 3'd5
  } match_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_P     = 7'h0C;

  localparam logic [3:0] ROUND_MAX = 4'd9;

  function automatic logic [3:0] next_round(input logic [3:0] cur);
    next_round = (cur >= ROUND_MAX) ? ROUND_MAX : cur + 4'd1;
  endfunction

endpackage

// File: rtl/match_controller_seg7_decoder.sv
// Hex digit to active-low 7-segment glyph, purely combinational.
module seg7_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: IDLE -> ROUND_RST -> COUNTDOWN -> FIGHT -> KO -> next round
// or MATCH_OVER, with score/round/countdown shown on six registered 7-seg digits.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int HEALTH_W       = 3,
  parameter int FPS            = 60,
  parameter int COUNTDOWN_SECS = 3,
  parameter int KO_FRAMES      = 120,
  parameter int ROUNDS_TO_WIN  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                start,
  input  logic [HEALTH_W-1:0] player1_health,
  input  logic [HEALTH_W-1:0] player2_health,
  output logic                round_rst,
  output logic                fight_enable,
  output match_state_t        match_state,
  output logic [1:0]          p1_wins,
  output logic [1:0]          p2_wins,
  output logic [3:0]          round_num,
  output logic [1:0]          winner,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic [6:0]          HEX4,
  output logic [6:0]          HEX5
);

  localparam int FRAME_W = (FPS > 1) ? $clog2(FPS) : 1;
  localparam int KO_W    = $clog2(KO_FRAMES + 1);

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FPS - 1);
  localparam logic [KO_W-1:0]    KO_LAST    = KO_W'(KO_FRAMES - 1);
  localparam logic [1:0]         SEC_INIT   = 2'(COUNTDOWN_SECS);
  localparam logic [1:0]         WINS_MAX   = 2'(ROUNDS_TO_WIN);

  match_state_t       state;
  logic [FRAME_W-1:0] frame_cnt;
  logic [KO_W-1:0]    ko_cnt;
  logic [1:0]         sec;

  logic p1_ko;
  logic p2_ko;

  assign p1_ko       = (player1_health == '0);
  assign p2_ko       = (player2_health == '0);
  assign match_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      round_rst    <= 1'b0;
      fight_enable <= 1'b0;
      p1_wins      <= 2'd0;
      p2_wins      <= 2'd0;
      round_num    <= 4'd1;
      winner       <= WIN_NONE;
      frame_cnt    <= '0;
      ko_cnt       <= '0;
      sec          <= 2'd0;
    end else begin
      round_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ROUND_RST;
            round_rst <= 1'b1;
          end
        end

        ROUND_RST: begin
          sec       <= SEC_INIT;
          frame_cnt <= '0;
          state     <= COUNTDOWN;
        end

        COUNTDOWN: begin
          if (frame_tick) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              sec       <= sec - 2'd1;
              if (sec == 2'd1) begin
                state        <= FIGHT;
                fight_enable <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + FRAME_W'(1);
            end
          end
        end

        FIGHT: begin
          // A double KO is a draw: the round ends but nobody scores.
          if (p1_ko || p2_ko) begin
            state        <= KO;
            ko_cnt       <= '0;
            fight_enable <= 1'b0;
            if (p1_ko && !p2_ko && p2_wins != WINS_MAX) p2_wins <= p2_wins + 2'd1;
            if (p2_ko && !p1_ko && p1_wins != WINS_MAX) p1_wins <= p1_wins + 2'd1;
          end
        end

        KO: begin
          if (frame_tick) begin
            if (ko_cnt == KO_LAST) begin
              if (p1_wins == WINS_MAX || p2_wins == WINS_MAX) begin
                state  <= MATCH_OVER;
                winner <= (p1_wins == WINS_MAX) ? WIN_P1 : WIN_P2;
              end else begin
                round_num <= next_round(round_num);
                state     <= ROUND_RST;
                round_rst <= 1'b1;
              end
            end else begin
              ko_cnt <= ko_cnt + KO_W'(1);
            end
          end
        end

        MATCH_OVER: begin
          if (start) begin
            p1_wins   <= 2'd0;
            p2_wins   <= 2'd0;
            round_num <= 4'd1;
            winner    <= WIN_NONE;
            state     <= ROUND_RST;
            round_rst <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  logic [6:0] seg_p1;
  logic [6:0] seg_p2;
  logic [6:0] seg_round;
  logic [6:0] seg_sec;
  logic [6:0] seg_winner;

  seg7_decoder u_seg_p1     (.digit({2'b00, p1_wins}), .seg(seg_p1));
  seg7_decoder u_seg_p2     (.digit({2'b00, p2_wins}), .seg(seg_p2));
  seg7_decoder u_seg_round  (.digit(round_num),        .seg(seg_round));
  seg7_decoder u_seg_sec    (.digit({2'b00, sec}),     .seg(seg_sec));
  seg7_decoder u_seg_winner (.digit({2'b00, winner}),  .seg(seg_winner));

  // Display stays dark until a match has been started.
  always_ff @(posedge clk) begin
    if (rst) begin
      HEX0 <= SEG_BLANK;
      HEX1 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX3 <= SEG_BLANK;
      HEX4 <= SEG_BLANK;
      HEX5 <= SEG_BLANK;
    end else begin
      HEX5 <= (state == IDLE)       ? SEG_BLANK : seg_p1;
      HEX0 <= (state == IDLE)       ? SEG_BLANK : seg_p2;
      HEX3 <= (state == IDLE)       ? SEG_BLANK : seg_round;
      HEX2 <= (state == COUNTDOWN)  ? seg_sec   : SEG_BLANK;
      HEX4 <= (state == MATCH_OVER) ? SEG_P     : SEG_BLANK;
      HEX1 <= (state == MATCH_OVER) ? seg_winner : SEG_BLANK;
    end
  end

endmodule
